// File: rtl/bit_frame_sync.sv
// rtl/bit_frame_sync.sv - serial bitstream sync hunter, length-header parser and byte packer
module bit_frame_sync #(
    parameter int                SYNC_W    = 32,
    parameter logic [SYNC_W-1:0] SYNC_WORD = 32'h1ACF_FC1D,
    parameter int                MAX_ERR   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       clear,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       frame_start,
    output logic       frame_end,
    output logic       locked
);

    localparam int CNT_W = $clog2(SYNC_W + 1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t            state_q;
    logic [SYNC_W-1:0] sr_q;
    logic [CNT_W-1:0]  fill_q;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        byte_cnt_q;
    logic [7:0]        len_q;
    logic [7:0]        shift_q;
    logic [7:0]        out_data_q;
    logic              out_valid_q;
    logic              frame_start_q;
    logic              frame_end_q;
    logic              locked_q;

    logic [SYNC_W-1:0] sr_d;
    logic [SYNC_W-1:0] diff;
    logic [CNT_W-1:0]  err_cnt;
    logic              sync_hit;
    logic [7:0]        byte_d;
    logic              last_bit;

    always_comb begin
        sr_d    = {sr_q[SYNC_W-2:0], bit_in};
        diff    = sr_d ^ SYNC_WORD;
        err_cnt = '0;
        for (int i = 0; i < SYNC_W; i++) begin
            err_cnt = err_cnt + CNT_W'(diff[i]);
        end
        // The window must hold SYNC_W fresh bits, i.e. this bit is at least the SYNC_W-th.
        sync_hit = (fill_q >= CNT_W'(SYNC_W - 1)) && (err_cnt <= CNT_W'(MAX_ERR));
        byte_d   = {shift_q[6:0], bit_in};
        last_bit = (bit_cnt_q == 3'd7);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            sr_q          <= '0;
            fill_q        <= '0;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            len_q         <= '0;
            shift_q       <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            if (clear) begin
                state_q    <= HUNT;
                sr_q       <= '0;
                fill_q     <= '0;
                bit_cnt_q  <= '0;
                byte_cnt_q <= '0;
                len_q      <= '0;
                shift_q    <= '0;
                locked_q   <= 1'b0;
            end else begin
                // locked lingers through the frame_end cycle, then falls once back in HUNT
                if (state_q == HUNT) begin
                    locked_q <= 1'b0;
                end
                if (bit_valid) begin
                    case (state_q)
                        HUNT: begin
                            if (sync_hit) begin
                                state_q       <= HEADER;
                                sr_q          <= '0;
                                fill_q        <= '0;
                                bit_cnt_q     <= '0;
                                frame_start_q <= 1'b1;
                                locked_q      <= 1'b1;
                            end else begin
                                sr_q <= sr_d;
                                if (fill_q != CNT_W'(SYNC_W)) begin
                                    fill_q <= fill_q + CNT_W'(1);
                                end
                            end
                        end
                        HEADER: begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            shift_q   <= byte_d;
                            if (last_bit) begin
                                len_q <= byte_d;
                                if (byte_d == 8'd0) begin
                                    state_q     <= HUNT;
                                    frame_end_q <= 1'b1;
                                end else begin
                                    state_q    <= PAYLOAD;
                                    byte_cnt_q <= byte_d;
                                end
                            end
                        end
                        PAYLOAD: begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            shift_q   <= byte_d;
                            if (last_bit) begin
                                out_data_q  <= byte_d;
                                out_valid_q <= 1'b1;
                                byte_cnt_q  <= byte_cnt_q - 8'd1;
                                if (byte_cnt_q == 8'd1) begin
                                    state_q     <= HUNT;
                                    frame_end_q <= 1'b1;
                                end
                            end
                        end
                        default: begin
                            state_q <= HUNT;
                        end
                    endcase
                end
            end
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_bit_frame_sync.sv
// tb/tb_bit_frame_sync.sv - scoreboard bench for bit_frame_sync with MAX_ERR=0 and MAX_ERR=1 instances
module tb_bit_frame_sync;

    localparam logic [31:0] SYNC     = 32'h1ACF_FC1D;
    localparam logic [31:0] SYNC_BAD = 32'h1ACF_FC1C;
    localparam logic [15:0] PRE      = 16'h5A96;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       clear = 1'b0;

    logic [7:0] d0_data, d1_data;
    logic       d0_ov, d0_fs, d0_fe, d0_lk;
    logic       d1_ov, d1_fs, d1_fe, d1_lk;

    bit_frame_sync #(.MAX_ERR(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
        .out_data(d0_data), .out_valid(d0_ov), .frame_start(d0_fs), .frame_end(d0_fe), .locked(d0_lk)
    );

    bit_frame_sync #(.MAX_ERR(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
        .out_data(d1_data), .out_valid(d1_ov), .frame_start(d1_fs), .frame_end(d1_fe), .locked(d1_lk)
    );

    always #5 clk = ~clk;

    typedef struct {
        time        t;
        logic       fs;
        logic       ov;
        logic       fe;
        logic [7:0] d;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    int         checks = 0;
    int         errors = 0;
    time        last_acc = 0;
    logic [7:0] pl [0:7];

    task automatic push_exp(input logic a0, input logic a1, input logic fs, input logic ov,
                            input logic fe, input logic [7:0] d);
        exp_t e;
        e.t  = last_acc + 5;
        e.fs = fs;
        e.ov = ov;
        e.fe = fe;
        e.d  = d;
        if (a0) q0.push_back(e);
        if (a1) q1.push_back(e);
    endtask

    task automatic check_dut(input int k, input logic fs, input logic ov, input logic fe,
                             input logic lk, input logic [7:0] d);
        exp_t e;
        logic ok;
        if (!(fs || ov || fe)) return;
        checks++;
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            errors++;
            $display("FAIL dut%0d unexpected_pulse at %0t: fs=%b ov=%b fe=%b data=%h, required no pulse",
                     k, $time, fs, ov, fe, d);
            return;
        end
        if (k == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        ok = (e.t == $time) && (fs == e.fs) && (ov == e.ov) && (fe == e.fe) && lk &&
             (!e.ov || d == e.d);
        if (!ok) begin
            errors++;
            $display("FAIL dut%0d event: got t=%0t fs=%b ov=%b fe=%b locked=%b data=%h, required t=%0t fs=%b ov=%b fe=%b locked=1 data=%h",
                     k, $time, fs, ov, fe, lk, d, e.t, e.fs, e.ov, e.fe, e.d);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check_dut(0, d0_fs, d0_ov, d0_fe, d0_lk, d0_data);
            check_dut(1, d1_fs, d1_ov, d1_fe, d1_lk, d1_data);
        end
    end

    task automatic check_zero(input string name);
        checks++;
        if ({d0_data, d0_ov, d0_fs, d0_fe, d0_lk, d1_data, d1_ov, d1_fs, d1_fe, d1_lk} != '0) begin
            errors++;
            $display("FAIL %s: dut0 data=%h ov=%b fs=%b fe=%b lk=%b dut1 data=%h ov=%b fs=%b fe=%b lk=%b, required all 0",
                     name, d0_data, d0_ov, d0_fs, d0_fe, d0_lk, d1_data, d1_ov, d1_fs, d1_fe, d1_lk);
        end
    endtask

    task automatic check_empty(input string name);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL %s missing_events: dut0 pending=%0d dut1 pending=%0d, required 0",
                     name, q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic send_bit(input logic b, input int gap);
        for (int g = 0; g < gap; g++) begin
            bit_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk);
        last_acc  = $time;
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 7; i >= 0; i--) send_bit(b[i], gap);
    endtask

    task automatic idle(input int n);
        bit_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_head(input logic [31:0] s, input logic [7:0] len, input int gap,
                             input logic a0, input logic a1);
        logic [15:0] p;
        p = PRE;
        for (int i = 15; i >= 0; i--) send_bit(p[i], gap);
        for (int i = 31; i >= 0; i--) send_bit(s[i], gap);
        push_exp(a0, a1, 1'b1, 1'b0, 1'b0, 8'h00);
        send_byte(len, gap);
        if (len == 8'd0) push_exp(a0, a1, 1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic send_frame(input logic [31:0] s, input logic [7:0] len, input int gap,
                              input logic a0, input logic a1);
        send_head(s, len, gap, a0, a1);
        for (int i = 0; i < int'(len); i++) begin
            send_byte(pl[i], gap);
            push_exp(a0, a1, 1'b0, 1'b1, (i == int'(len) - 1), pl[i]);
        end
    endtask

    task automatic pulse_clear();
        clear     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        @(posedge clk);
        #1;
        clear     = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic set_pl2(input logic [7:0] a, input logic [7:0] b);
        pl[0] = a;
        pl[1] = b;
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bit_in    = 1'($urandom);
            bit_valid = 1'($urandom);
            @(negedge clk);
            check_zero("reset_hold");
        end
        bit_valid = 1'b0;
        rst_n     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_zero("after_release");
        end

        set_pl2(8'hA5, 8'h3C);
        send_frame(SYNC, 8'd2, 0, 1'b1, 1'b1);
        idle(4);
        check_empty("clean_frame");

        pulse_clear();
        send_frame(SYNC_BAD, 8'd2, 0, 1'b0, 1'b1);
        idle(4);
        check_empty("one_bit_error");

        pulse_clear();
        send_frame(SYNC, 8'd0, 0, 1'b1, 1'b1);
        idle(4);
        check_empty("zero_length");

        pulse_clear();
        set_pl2(8'hA5, 8'h3C);
        send_frame(SYNC, 8'd2, 2, 1'b1, 1'b1);
        idle(4);
        check_empty("gapped");

        pulse_clear();
        pl[0] = 8'h1A; pl[1] = 8'hCF; pl[2] = 8'hFC; pl[3] = 8'h1D;
        send_frame(SYNC, 8'd4, 0, 1'b1, 1'b1);
        idle(4);
        check_empty("sync_in_payload");

        pulse_clear();
        pl[0] = 8'h11;
        send_head(SYNC, 8'd4, 0, 1'b1, 1'b1);
        send_byte(pl[0], 0);
        push_exp(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, pl[0]);
        for (int i = 0; i < 4; i++) send_bit(1'(i), 0);
        pulse_clear();
        @(negedge clk);
        checks++;
        if (d0_lk || d1_lk) begin
            errors++;
            $display("FAIL clear_locked: dut0=%b dut1=%b, required 0", d0_lk, d1_lk);
        end
        idle(10);
        check_empty("clear_abort");
        set_pl2(8'h5E, 8'h81);
        send_frame(SYNC, 8'd2, 0, 1'b1, 1'b1);
        idle(4);
        check_empty("after_clear");

        pulse_clear();
        send_head(SYNC, 8'd2, 0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
        rst_n = 1'b0;
        #1;
        check_zero("reset_midframe");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_pl2(8'hC3, 8'h00);
        send_frame(SYNC, 8'd2, 0, 1'b1, 1'b1);
        idle(5);
        check_empty("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
